// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480 @ 60 Hz timing constants shared by the VGA timing slice.
package vga_timing_pkg;

   localparam int unsigned COORD_W     = 10;
   localparam int unsigned FRAME_CNT_W = 8;

   localparam int unsigned H_VISIBLE_DEF = 640;
   localparam int unsigned H_FRONT_DEF   = 16;
   localparam int unsigned H_SYNC_DEF    = 96;
   localparam int unsigned H_BACK_DEF    = 48;

   localparam int unsigned V_VISIBLE_DEF = 480;
   localparam int unsigned V_FRONT_DEF   = 10;
   localparam int unsigned V_SYNC_DEF    = 2;
   localparam int unsigned V_BACK_DEF    = 33;

   // Sync pulses are active low, so the idle level of a sync line is 1
   localparam logic SYNC_IDLE = 1'b1;

   // Length of a line or frame from its four timing segments
   function automatic int unsigned seg_total(input int unsigned visible, input int unsigned front,
                                             input int unsigned sync, input int unsigned back);
      return visible + front + sync + back;
   endfunction

   localparam int unsigned H_TOTAL_DEF = seg_total(H_VISIBLE_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF);
   localparam int unsigned V_TOTAL_DEF = seg_total(V_VISIBLE_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF);

endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: pixel coordinates, syncs and strobes handed to the renderers.
interface vga_timing_gen_if;
   import vga_timing_pkg::*;

   logic [COORD_W-1:0]     DrawX;
   logic [COORD_W-1:0]     DrawY;
   logic                   blank;
   logic                   hs;
   logic                   vs;
   logic                   line_start;
   logic                   frame_start;
   logic [FRAME_CNT_W-1:0] frame_cnt;

   modport master (
      output DrawX, DrawY, blank, hs, vs, line_start, frame_start, frame_cnt
   );

   modport slave (
      input DrawX, DrawY, blank, hs, vs, line_start, frame_start, frame_cnt
   );

endinterface

// File: rtl/sync_delay_line.sv
// sync_delay_line: fixed-depth shift register that holds the monitor syncs back so they
// line up with the renderers' registered colour outputs. Depth 0 is a plain wire.
module sync_delay_line #(
   parameter int               WIDTH     = 2,
   parameter int               DEPTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   generate
      if (DEPTH == 0) begin : g_pass
         // Clock and reset have nothing to drive when the line has no stages
         logic unused_clk_rst;
         assign unused_clk_rst = clk_i ^ rst_n_i;
         assign q_o = d_i;
      end else begin : g_pipe
         logic [WIDTH-1:0] stage_q [DEPTH];

         // Shift one stage per clock; every stage restarts at the idle level
         always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
               for (int i = 0; i < DEPTH; i++) stage_q[i] <= RESET_VAL;
            end else begin
               stage_q[0] <= d_i;
               for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
            end
         end

         assign q_o = stage_q[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running 640x480 @ 60 Hz pixel timing. Counters hc/vc are decoded
// into registered coordinates, blank and strobes; syncs get PIPE_DLY extra stages.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
   parameter int unsigned H_FRONT   = H_FRONT_DEF,
   parameter int unsigned H_SYNC    = H_SYNC_DEF,
   parameter int unsigned H_BACK    = H_BACK_DEF,
   parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
   parameter int unsigned V_FRONT   = V_FRONT_DEF,
   parameter int unsigned V_SYNC    = V_SYNC_DEF,
   parameter int unsigned V_BACK    = V_BACK_DEF,
   parameter int unsigned PIPE_DLY  = 1
) (
   input  logic             vga_clk,
   input  logic             reset_n,
   vga_timing_gen_if.master vga
);

   localparam int unsigned H_TOTAL = seg_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
   localparam int unsigned V_TOTAL = seg_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

   localparam logic [COORD_W-1:0] H_LAST    = COORD_W'(H_TOTAL - 1);
   localparam logic [COORD_W-1:0] V_LAST    = COORD_W'(V_TOTAL - 1);
   localparam logic [COORD_W-1:0] H_VIS_END = COORD_W'(H_VISIBLE);
   localparam logic [COORD_W-1:0] V_VIS_END = COORD_W'(V_VISIBLE);
   localparam logic [COORD_W-1:0] HS_START  = COORD_W'(H_VISIBLE + H_FRONT);
   localparam logic [COORD_W-1:0] HS_END    = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [COORD_W-1:0] VS_START  = COORD_W'(V_VISIBLE + V_FRONT);
   localparam logic [COORD_W-1:0] VS_END    = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC);

   logic [COORD_W-1:0]     hc_q, hc_d;
   logic [COORD_W-1:0]     vc_q, vc_d;
   logic [COORD_W-1:0]     draw_x_q, draw_y_q;
   logic                   blank_q;
   logic                   hs_raw_q, vs_raw_q;
   logic                   line_start_q, frame_start_q;
   logic                   first_frame_q;
   logic [FRAME_CNT_W-1:0] frame_cnt_q;
   logic                   at_line_start, at_frame_start;
   logic [1:0]             sync_dly;

   assign at_line_start  = (hc_q == '0);
   assign at_frame_start = at_line_start && (vc_q == '0);

   // Next pixel position: hc wraps every line and carries into vc
   always_comb begin
      hc_d = hc_q + COORD_W'(1);
      vc_d = vc_q;
      if (hc_q == H_LAST) begin
         hc_d = '0;
         vc_d = (vc_q == V_LAST) ? '0 : vc_q + COORD_W'(1);
      end
   end

   // Position counters, restarting at the top-left pixel
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         hc_q <= '0;
         vc_q <= '0;
      end else begin
         hc_q <= hc_d;
         vc_q <= vc_d;
      end
   end

   // Register coordinates and the decodes of the current counter position
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         draw_x_q      <= '0;
         draw_y_q      <= '0;
         blank_q       <= 1'b0;
         hs_raw_q      <= SYNC_IDLE;
         vs_raw_q      <= SYNC_IDLE;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         draw_x_q      <= hc_q;
         draw_y_q      <= vc_q;
         blank_q       <= (hc_q < H_VIS_END) && (vc_q < V_VIS_END);
         hs_raw_q      <= ~((hc_q >= HS_START) && (hc_q < HS_END));
         vs_raw_q      <= ~((vc_q >= VS_START) && (vc_q < VS_END));
         line_start_q  <= at_line_start;
         frame_start_q <= at_frame_start;
      end
   end

   // Frame counter: the first frame after reset is frame 0, so its pulse only clears the flag
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         frame_cnt_q   <= '0;
         first_frame_q <= 1'b1;
      end else if (at_frame_start) begin
         if (first_frame_q) first_frame_q <= 1'b0;
         else               frame_cnt_q   <= frame_cnt_q + FRAME_CNT_W'(1);
      end
   end

   sync_delay_line #(
      .WIDTH     (2),
      .DEPTH     (int'(PIPE_DLY)),
      .RESET_VAL ({SYNC_IDLE, SYNC_IDLE})
   ) u_sync_dly (
      .clk_i   (vga_clk),
      .rst_n_i (reset_n),
      .d_i     ({hs_raw_q, vs_raw_q}),
      .q_o     (sync_dly)
   );

   assign vga.DrawX       = draw_x_q;
   assign vga.DrawY       = draw_y_q;
   assign vga.blank       = blank_q;
   assign vga.hs          = sync_dly[1];
   assign vga.vs          = sync_dly[0];
   assign vga.line_start  = line_start_q;
   assign vga.frame_start = frame_start_q;
   assign vga.frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of the VGA timing generator. Full 800-pixel lines
// are used throughout; vertical timing is shortened so several frames fit in a short run.
module tb_vga_timing_gen;
   import vga_timing_pkg::*;

   logic vga_clk = 1'b0;
   logic reset_n = 1'b1;
   int   checks  = 0;
   int   errors  = 0;
   // Edges seen since reset release; sample n shows the output of the n-th edge
   int   n       = 0;

   vga_timing_gen_if if_d ();
   vga_timing_gen_if if_a ();
   vga_timing_gen_if if_b ();
   vga_timing_gen_if if_c ();
   vga_timing_gen_if if_w ();

   // Full default timing
   vga_timing_gen dut_d (.vga_clk(vga_clk), .reset_n(reset_n), .vga(if_d));

   // 800-pixel lines, 10-line frames (4 visible, front 2, sync 2, back 2), three sync delays
   vga_timing_gen #(.V_VISIBLE(4), .V_FRONT(2), .V_SYNC(2), .V_BACK(2), .PIPE_DLY(1))
      dut_a (.vga_clk(vga_clk), .reset_n(reset_n), .vga(if_a));
   vga_timing_gen #(.V_VISIBLE(4), .V_FRONT(2), .V_SYNC(2), .V_BACK(2), .PIPE_DLY(0))
      dut_b (.vga_clk(vga_clk), .reset_n(reset_n), .vga(if_b));
   vga_timing_gen #(.V_VISIBLE(4), .V_FRONT(2), .V_SYNC(2), .V_BACK(2), .PIPE_DLY(3))
      dut_c (.vga_clk(vga_clk), .reset_n(reset_n), .vga(if_c));

   // Tiny 8x5 raster, 40-cycle frames, for the frame counter wrap
   vga_timing_gen #(.H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
                    .V_VISIBLE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .PIPE_DLY(1))
      dut_w (.vga_clk(vga_clk), .reset_n(reset_n), .vga(if_w));

   always #20 vga_clk = ~vga_clk;

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected bench completion");
      $fatal(1);
   end

   task automatic tick();
      @(negedge vga_clk);
      n++;
   endtask

   task automatic test_reset();
      #1 reset_n = 1'b0;
      repeat (5) @(negedge vga_clk);
      checks++; if (if_a.DrawX !== 10'd0) begin errors++; $display("[TB] FAIL rst_drawx: got %0d expected 0", if_a.DrawX); end
      checks++; if (if_a.DrawY !== 10'd0) begin errors++; $display("[TB] FAIL rst_drawy: got %0d expected 0", if_a.DrawY); end
      checks++; if (if_a.blank !== 1'b0) begin errors++; $display("[TB] FAIL rst_blank: got %b expected 0", if_a.blank); end
      checks++; if (if_a.hs !== 1'b1) begin errors++; $display("[TB] FAIL rst_hs: got %b expected 1", if_a.hs); end
      checks++; if (if_a.vs !== 1'b1) begin errors++; $display("[TB] FAIL rst_vs: got %b expected 1", if_a.vs); end
      checks++; if (if_a.line_start !== 1'b0) begin errors++; $display("[TB] FAIL rst_line_start: got %b expected 0", if_a.line_start); end
      checks++; if (if_a.frame_start !== 1'b0) begin errors++; $display("[TB] FAIL rst_frame_start: got %b expected 0", if_a.frame_start); end
      checks++; if (if_a.frame_cnt !== 8'd0) begin errors++; $display("[TB] FAIL rst_frame_cnt: got %0d expected 0", if_a.frame_cnt); end
      checks++; if (if_c.hs !== 1'b1) begin errors++; $display("[TB] FAIL rst_hs_dly3: got %b expected 1", if_c.hs); end
      checks++; if (if_d.blank !== 1'b0) begin errors++; $display("[TB] FAIL rst_blank_default: got %b expected 0", if_d.blank); end
      reset_n = 1'b1;
      n = 0;
      #1;
      checks++; if (if_a.blank !== 1'b0) begin errors++; $display("[TB] FAIL release_before_edge_blank: got %b expected 0", if_a.blank); end
      tick();
      checks++; if (if_a.DrawX !== 10'd0) begin errors++; $display("[TB] FAIL first_drawx: got %0d expected 0", if_a.DrawX); end
      checks++; if (if_a.DrawY !== 10'd0) begin errors++; $display("[TB] FAIL first_drawy: got %0d expected 0", if_a.DrawY); end
      checks++; if (if_a.blank !== 1'b1) begin errors++; $display("[TB] FAIL first_blank: got %b expected 1", if_a.blank); end
      checks++; if (if_a.line_start !== 1'b1) begin errors++; $display("[TB] FAIL first_line_start: got %b expected 1", if_a.line_start); end
      checks++; if (if_a.frame_start !== 1'b1) begin errors++; $display("[TB] FAIL first_frame_start: got %b expected 1", if_a.frame_start); end
      checks++; if (if_a.frame_cnt !== 8'd0) begin errors++; $display("[TB] FAIL first_frame_cnt: got %0d expected 0", if_a.frame_cnt); end
      checks++; if (if_a.hs !== 1'b1 || if_a.vs !== 1'b1) begin errors++; $display("[TB] FAIL first_syncs: got hs=%b vs=%b expected 1 1", if_a.hs, if_a.vs); end
      checks++; if (if_d.frame_start !== 1'b1) begin errors++; $display("[TB] FAIL first_frame_start_default: got %b expected 1", if_d.frame_start); end
   endtask

   // Line 0: DrawX walk, hs window, blank window, line_start, and the hs delay sweep
   task automatic test_line_timing();
      int   bad_x = 0, hs_low = 0, hs_first = -1, blank_low = 0, blank_first = -1, ls_cnt = 0;
      int   fall_a = -1, fall_b = -1, fall_c = -1, fall_d = -1;
      logic prev_a = 1'b1, prev_b = 1'b1, prev_c = 1'b1, prev_d = 1'b1;
      for (int i = 0; i < 800; i++) begin
         if (if_a.DrawX !== 10'(i) || if_a.DrawY !== 10'd0) bad_x++;
         if (if_d.DrawX !== 10'(i) || if_d.DrawY !== 10'd0) bad_x++;
         if (if_a.hs === 1'b0) begin hs_low++; if (hs_first < 0) hs_first = i; end
         if (if_a.blank === 1'b0) begin blank_low++; if (blank_first < 0) blank_first = i; end
         if (if_a.line_start === 1'b1) ls_cnt++;
         if (prev_a === 1'b1 && if_a.hs === 1'b0) fall_a = i;
         if (prev_b === 1'b1 && if_b.hs === 1'b0) fall_b = i;
         if (prev_c === 1'b1 && if_c.hs === 1'b0) fall_c = i;
         if (prev_d === 1'b1 && if_d.hs === 1'b0) fall_d = i;
         prev_a = if_a.hs; prev_b = if_b.hs; prev_c = if_c.hs; prev_d = if_d.hs;
         tick();
      end
      checks++; if (bad_x !== 0) begin errors++; $display("[TB] FAIL line_drawx_walk: got %0d bad samples expected 0", bad_x); end
      checks++; if (hs_low !== 96) begin errors++; $display("[TB] FAIL line_hs_width: got %0d expected 96", hs_low); end
      checks++; if (hs_first !== 657) begin errors++; $display("[TB] FAIL line_hs_first_low: got %0d expected 657", hs_first); end
      checks++; if (blank_low !== 160) begin errors++; $display("[TB] FAIL line_blank_width: got %0d expected 160", blank_low); end
      checks++; if (blank_first !== 640) begin errors++; $display("[TB] FAIL line_blank_first: got %0d expected 640", blank_first); end
      checks++; if (ls_cnt !== 1) begin errors++; $display("[TB] FAIL line_start_count: got %0d expected 1", ls_cnt); end
      checks++; if (fall_b !== 656) begin errors++; $display("[TB] FAIL sweep_dly0_hs_fall: got %0d expected 656", fall_b); end
      checks++; if (fall_a !== 657) begin errors++; $display("[TB] FAIL sweep_dly1_hs_fall: got %0d expected 657", fall_a); end
      checks++; if (fall_c !== 659) begin errors++; $display("[TB] FAIL sweep_dly3_hs_fall: got %0d expected 659", fall_c); end
      checks++; if (fall_d !== 657) begin errors++; $display("[TB] FAIL default_hs_fall: got %0d expected 657", fall_d); end
      checks++; if (if_a.DrawX !== 10'd0 || if_a.DrawY !== 10'd1) begin errors++; $display("[TB] FAIL line_wrap_pos: got %0d/%0d expected 0/1", if_a.DrawX, if_a.DrawY); end
      checks++; if (if_a.line_start !== 1'b1) begin errors++; $display("[TB] FAIL line_start_next: got %b expected 1", if_a.line_start); end
      checks++; if (if_a.frame_start !== 1'b0) begin errors++; $display("[TB] FAIL line1_frame_start: got %b expected 0", if_a.frame_start); end
      checks++; if (if_d.DrawY !== 10'd1) begin errors++; $display("[TB] FAIL default_line_wrap_drawy: got %0d expected 1", if_d.DrawY); end
   endtask

   // Two short frames: position/blank model, vs windows, frame_start spacing, frame_cnt steps
   task automatic test_frame_timing();
      int   bad_pos = 0, vs_low = 0, vs_falls = 0, vs_fall0 = -1, vs_fall1 = -1, vsb_fall0 = -1;
      int   fs_cnt = 0, fs_n0 = -1, fs_n1 = -1, fc0 = -1, fc1 = -1;
      int   ex, ey;
      logic eb;
      logic prev_vs = 1'b1, prev_vsb = 1'b1;
      for (int k = 0; k < 15201; k++) begin
         ex = (n - 1) % 800;
         ey = ((n - 1) / 800) % 10;
         eb = (ex < 640) && (ey < 4);
         if (if_a.DrawX !== 10'(ex) || if_a.DrawY !== 10'(ey) || if_a.blank !== eb) bad_pos++;
         if (if_a.vs === 1'b0) vs_low++;
         if (prev_vs === 1'b1 && if_a.vs === 1'b0) begin
            if (vs_falls == 0) vs_fall0 = n;
            else if (vs_falls == 1) vs_fall1 = n;
            vs_falls++;
         end
         if (prev_vsb === 1'b1 && if_b.vs === 1'b0 && vsb_fall0 < 0) vsb_fall0 = n;
         prev_vs = if_a.vs;
         prev_vsb = if_b.vs;
         if (if_a.frame_start === 1'b1) begin
            if (fs_cnt == 0) begin fs_n0 = n; fc0 = int'(if_a.frame_cnt); end
            else if (fs_cnt == 1) begin fs_n1 = n; fc1 = int'(if_a.frame_cnt); end
            fs_cnt++;
         end
         tick();
      end
      checks++; if (bad_pos !== 0) begin errors++; $display("[TB] FAIL frame_position_model: got %0d bad samples expected 0", bad_pos); end
      checks++; if (vs_low !== 3200) begin errors++; $display("[TB] FAIL frame_vs_low_total: got %0d expected 3200", vs_low); end
      checks++; if (vs_falls !== 2) begin errors++; $display("[TB] FAIL frame_vs_pulses: got %0d expected 2", vs_falls); end
      checks++; if (vs_fall0 !== 4802) begin errors++; $display("[TB] FAIL frame_vs_first_low: got %0d expected 4802", vs_fall0); end
      checks++; if (vs_fall1 !== 12802) begin errors++; $display("[TB] FAIL frame_vs_second_low: got %0d expected 12802", vs_fall1); end
      checks++; if (vsb_fall0 !== 4801) begin errors++; $display("[TB] FAIL frame_vs_dly0_first_low: got %0d expected 4801", vsb_fall0); end
      checks++; if (fs_cnt !== 2) begin errors++; $display("[TB] FAIL frame_start_count: got %0d expected 2", fs_cnt); end
      checks++; if (fs_n0 !== 8001 || fs_n1 !== 16001) begin errors++; $display("[TB] FAIL frame_start_spacing: got %0d,%0d expected 8001,16001", fs_n0, fs_n1); end
      checks++; if (fc0 !== 1 || fc1 !== 2) begin errors++; $display("[TB] FAIL frame_cnt_steps: got %0d,%0d expected 1,2", fc0, fc1); end
   endtask

   // Tiny raster crosses frame 511 -> 512, i.e. frame_cnt 255 -> 0
   task automatic test_frame_cnt_wrap();
      int bad_w = 0, starts = 0, wraps = 0;
      int efc;
      for (int k = 0; k < 4560; k++) begin
         efc = ((n - 1) / 40) % 256;
         if (if_w.frame_cnt !== 8'(efc)) bad_w++;
         if (if_w.frame_start !== (((n - 1) % 40) == 0)) bad_w++;
         if (if_w.frame_start === 1'b1) begin
            starts++;
            if (if_w.frame_cnt === 8'd0) wraps++;
         end
         if (n == 20441) begin
            checks++; if (if_w.frame_cnt !== 8'd255) begin errors++; $display("[TB] FAIL wrap_before: got %0d expected 255", if_w.frame_cnt); end
         end
         if (n == 20481) begin
            checks++; if (if_w.frame_cnt !== 8'd0) begin errors++; $display("[TB] FAIL wrap_after: got %0d expected 0", if_w.frame_cnt); end
         end
         tick();
      end
      checks++; if (bad_w !== 0) begin errors++; $display("[TB] FAIL wrap_cnt_model: got %0d bad samples expected 0", bad_w); end
      checks++; if (starts !== 114) begin errors++; $display("[TB] FAIL wrap_frame_starts: got %0d expected 114", starts); end
      checks++; if (wraps !== 1) begin errors++; $display("[TB] FAIL wrap_count: got %0d expected 1", wraps); end
   endtask

   // Reset asserted mid-frame at DrawX=300, DrawY=2, between clock edges
   task automatic test_mid_frame_reset();
      for (int k = 0; k < 8000 && ((n - 1) % 8000) != 1900; k++) tick();
      checks++; if (if_a.DrawX !== 10'd300 || if_a.DrawY !== 10'd2) begin errors++; $display("[TB] FAIL mid_target_pos: got %0d/%0d expected 300/2", if_a.DrawX, if_a.DrawY); end
      checks++; if (if_a.frame_cnt !== 8'd3) begin errors++; $display("[TB] FAIL mid_frame_cnt_before: got %0d expected 3", if_a.frame_cnt); end
      #5 reset_n = 1'b0;
      #1;
      checks++; if (if_a.DrawX !== 10'd0 || if_a.DrawY !== 10'd0) begin errors++; $display("[TB] FAIL mid_async_pos: got %0d/%0d expected 0/0", if_a.DrawX, if_a.DrawY); end
      checks++; if (if_a.blank !== 1'b0) begin errors++; $display("[TB] FAIL mid_async_blank: got %b expected 0", if_a.blank); end
      checks++; if (if_a.frame_cnt !== 8'd0) begin errors++; $display("[TB] FAIL mid_async_frame_cnt: got %0d expected 0", if_a.frame_cnt); end
      checks++; if (if_c.hs !== 1'b1 || if_c.vs !== 1'b1) begin errors++; $display("[TB] FAIL mid_async_syncs: got hs=%b vs=%b expected 1 1", if_c.hs, if_c.vs); end
      repeat (3) @(negedge vga_clk);
      reset_n = 1'b1;
      n = 0;
      tick();
      checks++; if (if_a.DrawX !== 10'd0 || if_a.DrawY !== 10'd0) begin errors++; $display("[TB] FAIL mid_restart_pos: got %0d/%0d expected 0/0", if_a.DrawX, if_a.DrawY); end
      checks++; if (if_a.blank !== 1'b1 || if_a.frame_start !== 1'b1) begin errors++; $display("[TB] FAIL mid_restart_strobes: got blank=%b fs=%b expected 1 1", if_a.blank, if_a.frame_start); end
      checks++; if (if_a.frame_cnt !== 8'd0) begin errors++; $display("[TB] FAIL mid_restart_frame_cnt: got %0d expected 0", if_a.frame_cnt); end
      repeat (4) tick();
      checks++; if (if_a.DrawX !== 10'd4 || if_a.line_start !== 1'b0) begin errors++; $display("[TB] FAIL mid_restart_advance: got x=%0d ls=%b expected 4 0", if_a.DrawX, if_a.line_start); end
      checks++; if (if_c.hs !== 1'b1) begin errors++; $display("[TB] FAIL mid_restart_hs: got %b expected 1", if_c.hs); end
   endtask

   initial begin
      $display("[TB] vga_timing_gen directed bench start");
      test_reset();
      test_line_timing();
      test_frame_timing();
      test_frame_cnt_wrap();
      test_mid_frame_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
